// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: registered MMIO interconnect between the CPU data port and
// N_SLAVES memory-mapped slaves.
//   The region code addr[SEL_HI:SEL_LO] selects one slave (lowest index wins
//   on multiple hits). A req/ready handshake then runs with that slave.
//   Unmapped addresses and slaves that stay silent past TIMEOUT wait cycles
//   return an error response.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cpu_req/we/addr/wdata           CPU request (sampled only in IDLE)
//   cpu_ready/rdata/err             one-cycle response strobe + held data/error
//   s_req                           one-hot slave request
//   s_we/s_addr/s_wdata             latched request, shared by all slaves
//   s_ready, s_rdata                per-slave completion and read-data slices
// Optional build macro MMIO_BUS_ERRLOG_EN adds an error log:
//   err_valid, err_addr (out), err_clr (in).
module mmio_bus_ctrl #(
  parameter int unsigned N_SLAVES = 8,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEL_HI   = 31,
  parameter int unsigned SEL_LO   = 28,
  parameter logic [N_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_MAP = 32'hFEDC_2100,
  parameter logic [N_SLAVES-1:0] SLAVE_EN = 8'h7F,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_ready,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_err,
  output logic [N_SLAVES-1:0]          s_req,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [N_SLAVES-1:0]          s_ready,
`ifdef MMIO_BUS_ERRLOG_EN
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  output logic                         err_valid,
  output logic [ADDR_W-1:0]            err_addr,
  input  logic                         err_clr
`else
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata
`endif
);

  localparam int unsigned SW = SEL_HI - SEL_LO + 1;
  localparam int unsigned IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [IW-1:0]    sel;
  logic [CW-1:0]    cnt;
  // Error responses (miss or timeout) spend one ACCESS cycle with no slave
  // selected, so they leave through the same path as a slave completion.
  logic             err_pend;

  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic             sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic [CW-1:0]    cnt_inc;
  logic             timeout_hit;

  // Region decode; scanning downwards leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
      if (SLAVE_EN[i] && (cpu_addr[SEL_HI:SEL_LO] == SLAVE_MAP[i*SW +: SW])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Selected slave's handshake and saturating wait counter.
  always_comb begin
    sel_ready   = s_ready[sel];
    sel_rdata   = s_rdata[32'(sel)*DATA_W +: DATA_W];
    cnt_inc     = (cnt == '1) ? cnt : cnt + CW'(1);
    timeout_hit = (TIMEOUT != 0) && (32'(cnt_inc) == TIMEOUT);
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      err_pend  <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      s_req     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            s_we     <= cpu_we;
            s_addr   <= cpu_addr;
            s_wdata  <= cpu_wdata;
            sel      <= hit_idx;
            cnt      <= '0;
            err_pend <= !hit;
            if (hit) s_req <= N_SLAVES'(1) << hit_idx;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (err_pend) begin
            err_pend  <= 1'b0;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end else if (sel_ready) begin
            s_req     <= '0;
            cpu_err   <= 1'b0;
            cpu_rdata <= s_we ? '0 : sel_rdata;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt_inc;
            // Drop the request now; the error leaves on the next cycle.
            if (timeout_hit) begin
              s_req    <= '0;
              err_pend <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MMIO_BUS_ERRLOG_EN
  logic log_err;
  assign log_err = (state == ACCESS) && err_pend;

  // First error is kept until cleared; a clear in the same cycle as a new
  // error lets the new one in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (log_err && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_addr  <= s_addr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl (default parameters).
// Expected responses are pushed to a scoreboard queue at request time and
// popped when cpu_ready is seen.
module tb_mmio_bus_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [7:0]  s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [7:0]  s_ready;
  logic [255:0] s_rdata;
`ifdef MMIO_BUS_ERRLOG_EN
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_clr;
`endif

  mmio_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready),
`ifdef MMIO_BUS_ERRLOG_EN
    .s_rdata(s_rdata),
    .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
`else
    .s_rdata(s_rdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Independent model of the default map {f,e,d,c,2,1,0,0}, slot 7 disabled.
  function automatic int ref_idx(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 0;
      4'h1:    return 2;
      4'h2:    return 3;
      4'hC:    return 4;
      4'hD:    return 5;
      4'hE:    return 6;
      default: return -1;
    endcase
  endfunction

  // One CPU access; waits < 0 means the slave never answers.
  task automatic run(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                     input int waits, input logic [31:0] sdata);
    int          idx;
    logic [7:0]  onehot;
    int          exp_sreq;
    int          nsreq;
    exp_t        e;
    exp_t        got;
    bit          done;
    idx    = ref_idx(addr);
    onehot = (idx >= 0) ? 8'(1) << idx : 8'h00;
    if (idx < 0) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 2; exp_sreq = 0;
    end else if (waits >= 0 && waits < TMO) begin
      e.rdata = we ? 32'h0 : sdata; e.err = 1'b0; e.lat = 2 + waits; exp_sreq = waits + 1;
    end else begin
      e.rdata = '0; e.err = 1'b1; e.lat = 2 + TMO; exp_sreq = TMO;
    end
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) s_rdata[i*32 +: 32] = (i == idx) ? sdata : (32'hDEAD_0000 | 32'(i));

    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'hFFFF_FFFF;
    nsreq = 0;
    done  = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      // Non-selected slaves shout ready the whole time; only the selected one matters.
      s_ready = ~onehot;
      if (idx >= 0 && waits >= 0 && c == waits + 1) s_ready = 8'hFF;
      @(negedge clk);
      if (c == 1) begin
        check("s_addr", 64'(s_addr), 64'(addr));
        check("s_we", 64'(s_we), 64'(we));
        check("s_wdata", 64'(s_wdata), 64'(wdata));
      end
      if (cpu_ready) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          check("sb_empty", 64'(1), 64'(0));
        end else begin
          got = exp_q.pop_front();
          check("rdata", 64'(cpu_rdata), 64'(got.rdata));
          check("err", 64'(cpu_err), 64'(got.err));
          check("latency", 64'(c), 64'(got.lat));
        end
      end else if (s_req != 8'h00) begin
        nsreq++;
        check("s_req_val", 64'(s_req), 64'(onehot));
      end
      @(posedge clk); #1;
    end
    s_ready = 8'h00;
    if (!done) check("resp_timeout", 64'(0), 64'(1));
    check("s_req_cycles", 64'(nsreq), 64'(exp_sreq));
    @(negedge clk);
    check("ready_pulse", 64'(cpu_ready), 64'(0));
    check("rdata_hold", 64'(cpu_rdata), 64'(e.rdata));
    check("err_hold", 64'(cpu_err), 64'(e.err));
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    s_ready = '0; s_rdata = '0;
`ifdef MMIO_BUS_ERRLOG_EN
    err_clr = 1'b0;
`endif
    #2;
    check("rst_ready", 64'(cpu_ready), 64'(0));
    check("rst_err", 64'(cpu_err), 64'(0));
    check("rst_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_s_req", 64'(s_req), 64'(0));
    check("rst_s_addr", 64'(s_addr), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run(32'h1000_0000, 1'b0, 32'h0, 0, 32'hA5A5_0001);   // code 1 -> slave 2, zero wait
    run(32'hE000_0000, 1'b1, 32'h1234, 3, 32'h5555_6666); // write, 3 waits
    run(32'h7000_0000, 1'b0, 32'h0, 0, 32'h1111_1111);   // unmapped
    run(32'h2000_0000, 1'b0, 32'h0, -1, 32'h2222_2222);  // slave 3 silent -> timeout
    run(32'hF000_0000, 1'b0, 32'h0, 0, 32'h3333_3333);   // disabled slot
    run(32'h0000_0040, 1'b0, 32'h0, 1, 32'h4444_0000);   // two slots hit, slave 0 wins
    run(32'h2000_0010, 1'b0, 32'h0, TMO - 1, 32'h7777_0001); // last wait before timeout
    run(32'h2000_0020, 1'b0, 32'h0, TMO, 32'h7777_0002); // one wait too many
    run(32'hC000_0000, 1'b1, 32'hCAFE_F00D, 0, 32'h8888_8888); // write returns 0

    // Reset during a slave wait aborts with no response.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2000_0000;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_s_req", 64'(s_req), 64'(8'h08));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_s_req", 64'(s_req), 64'(0));
    check("async_rst_ready", 64'(cpu_ready), 64'(0));
    repeat (2) begin
      @(negedge clk);
      check("rst_no_ready", 64'(cpu_ready), 64'(0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    run(32'hD000_0000, 1'b0, 32'h0, 2, 32'hBEEF_0005);

    // Random traffic over all region codes.
    for (int k = 0; k < 10; k++) begin
      logic [31:0] a;
      a = {4'($urandom_range(0, 15)), 28'($urandom)};
      run(a, 1'($urandom), $urandom, int'($urandom_range(0, 5)), $urandom);
    end

`ifdef MMIO_BUS_ERRLOG_EN
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("log_cleared", 64'(err_valid), 64'(0));
    run(32'h7000_0000, 1'b0, 32'h0, 0, 32'h0);
    check("log_valid", 64'(err_valid), 64'(1));
    check("log_addr1", 64'(err_addr), 64'(32'h7000_0000));
    run(32'h8000_0000, 1'b0, 32'h0, 0, 32'h0);
    check("log_kept", 64'(err_addr), 64'(32'h7000_0000));
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("log_clr", 64'(err_valid), 64'(0));
    run(32'h9000_0000, 1'b0, 32'h0, 0, 32'h0);
    check("log_valid3", 64'(err_valid), 64'(1));
    check("log_addr3", 64'(err_addr), 64'(32'h9000_0000));
`endif

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
